// File: rtl/dcache_line_fill.sv
// Data-cache line fill engine. On a miss it issues one burst read for the
// whole line, collects the beats into a line buffer, forwards the requested
// word early (critical word), and writes the full line into the data RAM.
`ifndef DCACHE_B
`define DCACHE_B 5
`endif
`ifndef DCACHE_S
`define DCACHE_S 7
`endif

module dcache_line_fill #(
   parameter int DATA_WIDTH  = 32,
   parameter int OFFSET_SIZE = 2 ** (`DCACHE_B - 2)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              miss_req,
   input  logic [31:0]                       miss_addr,
   output logic                              fill_busy,
   output logic                              fill_done,
   output logic                              crit_ok,
   output logic [DATA_WIDTH-1:0]             crit_data,
   output logic                              rd_req,
   output logic [31:0]                       rd_addr,
   output logic [7:0]                        rd_len,
   input  logic                              rd_addr_ok,
   input  logic [DATA_WIDTH-1:0]             rd_data,
   input  logic                              rd_data_ok,
   output logic [`DCACHE_S-1:0]              ram_addr,
   output logic [DATA_WIDTH*OFFSET_SIZE-1:0] ram_din,
   output logic                              ram_wen,
   output logic [1:0]                        ram_size,
   output logic [`DCACHE_B-3:0]              ram_offset,
   output logic [1:0]                        ram_bit_pos,
   output logic [1:0]                        o_dbg_state,
   output logic [31:0]                       o_dbg_addr
);

   // Handshakes: rd_req is the request valid; rd_addr and rd_len are held
   // constant while rd_req is high and rd_addr_ok is low, and the request is
   // taken in the cycle where rd_req and rd_addr_ok are both high.
   // rd_data_ok is a pure valid strobe: every beat it marks is consumed in
   // that cycle while receiving, and ignored in any other state.

   localparam int OFF_W = `DCACHE_B - 2;
   localparam int CNT_W = OFF_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_RECV  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t                              r_state;
   state_t                              w_next_state;
   logic [31:0]                         r_addr;
   logic [CNT_W-1:0]                    r_count;
   logic [DATA_WIDTH*OFFSET_SIZE-1:0]   r_line;
   logic                                r_crit_ok;
   logic [DATA_WIDTH-1:0]               r_crit_data;

   logic                                w_beat;
   logic                                w_last;
   logic                                w_is_crit;

   assign w_beat    = (r_state == S_RECV) && rd_data_ok;
   assign w_last    = (r_count == CNT_W'(OFFSET_SIZE - 1));
   assign w_is_crit = (r_count == {1'b0, r_addr[`DCACHE_B-1:2]});

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state decode and state-dependent outputs
   always_comb begin
      w_next_state = r_state;
      fill_busy    = 1'b1;
      fill_done    = 1'b0;
      ram_wen      = 1'b0;
      rd_req       = 1'b0;
      rd_addr      = 32'd0;
      rd_len       = 8'd0;
      case (r_state)
         S_IDLE: begin
            fill_busy = 1'b0;
            if (miss_req) w_next_state = S_REQ;
         end
         S_REQ: begin
            rd_req  = 1'b1;
            rd_addr = {r_addr[31:`DCACHE_B], {`DCACHE_B{1'b0}}};
            rd_len  = 8'(OFFSET_SIZE - 1);
            if (rd_addr_ok) w_next_state = S_RECV;
         end
         S_RECV: begin
            if (w_beat && w_last) w_next_state = S_WRITE;
         end
         S_WRITE: begin
            fill_done    = 1'b1;
            ram_wen      = 1'b1;
            w_next_state = S_IDLE;
         end
         default: begin
            fill_busy    = 1'b0;
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Capture the miss address when a fill is accepted
   always_ff @(posedge clk) begin
      if (reset)                            r_addr <= 32'd0;
      else if (r_state == S_IDLE && miss_req) r_addr <= miss_addr;
   end

   // Beat counter: cleared when the burst is accepted, one step per beat
   always_ff @(posedge clk) begin
      if (reset)                                 r_count <= '0;
      else if (r_state == S_REQ && rd_addr_ok)   r_count <= '0;
      else if (w_beat)                           r_count <= r_count + CNT_W'(1);
   end

   // Line buffer: each beat lands in the word selected by the counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_line <= '0;
      end else begin
         for (int k = 0; k < OFFSET_SIZE; k++) begin
            if (w_beat && (r_count == CNT_W'(k)))
               r_line[k*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
         end
      end
   end

   // Early-restart pulse one cycle after the requested word arrives
   always_ff @(posedge clk) begin
      if (reset) begin
         r_crit_ok   <= 1'b0;
         r_crit_data <= '0;
      end else begin
         r_crit_ok <= w_beat && w_is_crit;
         if (w_beat && w_is_crit) r_crit_data <= rd_data;
      end
   end

   assign crit_ok     = r_crit_ok;
   assign crit_data   = r_crit_data;
   assign ram_addr    = r_addr[`DCACHE_B+`DCACHE_S-1:`DCACHE_B];
   assign ram_din     = r_line;
   assign ram_size    = 2'b11;
   assign ram_offset  = '0;
   assign ram_bit_pos = 2'b00;
   assign o_dbg_state = r_state;
   assign o_dbg_addr  = r_addr;

endmodule
